// File: rtl/output_error_unit.sv
`default_nettype none
// ============================================================================
// Module   : output_error_unit
// Brief    : Output-error stage after the final perceptron layer: registered
//            gradient (prediction - target), one-cycle train strobe, batch MSE
//            loss and epoch counter. Loss path built only when
//            OUTPUT_ERROR_LOSS_EN is defined.
//            sfp = signed fixed point, SFP_WIDTH bits with 8 fraction bits.
// Revision : 1.0
// ============================================================================
module output_error_unit #(
    parameter int output_units = 2,
    parameter int batch_size   = 4,
    parameter int SFP_WIDTH    = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [SFP_WIDTH-1:0]          prediction     [output_units-1:0],
    input  logic signed [SFP_WIDTH-1:0]          target         [output_units-1:0],
    output logic signed [SFP_WIDTH-1:0]          error_gradient [output_units-1:0],
    output logic                                 grad_valid,
    output logic                                 train,
    output logic signed [SFP_WIDTH-1:0]          loss,
    output logic                                 loss_valid,
    output logic [$clog2(batch_size+1)-1:0]      sample_count,
    output logic [15:0]                          epoch_count
);

    localparam int c_CNT_W = $clog2(batch_size + 1);
    localparam int c_ELEMS = batch_size * output_units;
    localparam logic [c_CNT_W-1:0]   c_BATCH   = c_CNT_W'(batch_size);
    localparam logic [SFP_WIDTH-1:0] c_SFP_MAX = {1'b0, {(SFP_WIDTH-1){1'b1}}};
    localparam logic [SFP_WIDTH-1:0] c_SFP_MIN = {1'b1, {(SFP_WIDTH-1){1'b0}}};

    generate
        if ((c_ELEMS & (c_ELEMS - 1)) != 0) begin : g_size_check
            $error("output_error_unit: batch_size*output_units must be a power of two");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_GRAD   = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;
    logic   w_batch_done;

    logic signed [SFP_WIDTH-1:0] w_diff [output_units-1:0];
    logic signed [SFP_WIDTH-1:0] r_grad [output_units-1:0];
    logic [c_CNT_W-1:0]          r_sample_count;
    logic [15:0]                 r_epoch_count;

    // Saturating subtract: overflow shows as disagreement of the top two bits.
    for (genvar i = 0; i < output_units; i++) begin : g_lane
        logic [SFP_WIDTH:0] w_diff_wide;
        assign w_diff_wide = {prediction[i][SFP_WIDTH-1], prediction[i]}
                           - {target[i][SFP_WIDTH-1], target[i]};
        assign w_diff[i] = (w_diff_wide[SFP_WIDTH] != w_diff_wide[SFP_WIDTH-1])
                         ? (w_diff_wide[SFP_WIDTH] ? c_SFP_MIN : c_SFP_MAX)
                         : w_diff_wide[SFP_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_batch_done = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (in_valid) begin
                    w_state_next = ST_GRAD;
                    w_accept     = 1'b1;
                end
            end
            ST_GRAD: begin
                if (r_sample_count == c_BATCH) begin
                    w_state_next = ST_REPORT;
                    w_batch_done = 1'b1;
                end else begin
                    w_state_next = ST_ACCEPT;
                end
            end
            ST_REPORT: w_state_next = ST_ACCEPT;
            default:   w_state_next = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < output_units; i++) begin
                r_grad[i] <= '0;
            end
            r_sample_count <= '0;
            r_epoch_count  <= '0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < output_units; i++) begin
                    r_grad[i] <= w_diff[i];
                end
                r_sample_count <= r_sample_count + c_CNT_W'(1);
            end
            if (w_batch_done) begin
                r_sample_count <= '0;
                r_epoch_count  <= r_epoch_count + 16'd1;
            end
        end
    end

    // rst gates in_ready directly so a source never sees ready during reset.
    assign in_ready       = (r_state == ST_ACCEPT) && !rst;
    assign grad_valid     = (r_state == ST_GRAD);
    assign train          = (r_state == ST_GRAD);
    assign error_gradient = r_grad;
    assign sample_count   = r_sample_count;
    assign epoch_count    = r_epoch_count;

`ifdef OUTPUT_ERROR_LOSS_EN
    localparam int c_SFP_FRAC   = 8;
    localparam int c_SUM_W      = SFP_WIDTH + $clog2(output_units) + 2;
    localparam int c_LOSS_SHIFT = $clog2(c_ELEMS);

    logic [SFP_WIDTH-1:0]        w_sq [output_units-1:0];
    logic [c_SUM_W-1:0]          w_sq_sum;
    logic [c_SUM_W-1:0]          w_acc_sum;
    logic signed [SFP_WIDTH-1:0] w_acc_next;
    logic signed [SFP_WIDTH-1:0] r_acc;
    logic signed [SFP_WIDTH-1:0] r_loss;

    // Squares are non-negative, so any set bit at or above the sign position
    // of the shifted product means the result exceeds the sfp maximum.
    for (genvar i = 0; i < output_units; i++) begin : g_square
        logic signed [2*SFP_WIDTH-1:0] w_prod;
        logic signed [2*SFP_WIDTH-1:0] w_prod_shift;
        assign w_prod       = w_diff[i] * w_diff[i];
        assign w_prod_shift = w_prod >>> c_SFP_FRAC;
        assign w_sq[i]      = (|w_prod_shift[2*SFP_WIDTH-1:SFP_WIDTH-1])
                            ? c_SFP_MAX : w_prod_shift[SFP_WIDTH-1:0];
    end

    always_comb begin
        w_sq_sum = '0;
        for (int i = 0; i < output_units; i++) begin
            w_sq_sum = w_sq_sum + c_SUM_W'(w_sq[i]);
        end
    end

    assign w_acc_sum  = c_SUM_W'(unsigned'(r_acc)) + w_sq_sum;
    assign w_acc_next = (w_acc_sum > c_SUM_W'(c_SFP_MAX)) ? c_SFP_MAX
                                                          : w_acc_sum[SFP_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_loss <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
        end else if (w_batch_done) begin
            r_loss <= r_acc >>> c_LOSS_SHIFT;
            r_acc  <= '0;
        end
    end

    assign loss       = r_loss;
    assign loss_valid = (r_state == ST_REPORT);
`else
    assign loss       = '0;
    assign loss_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_output_error_unit.sv
`default_nettype none
// Directed self-checking bench for output_error_unit (2 outputs, batch of 4).
module tb_output_error_unit;

`ifdef OUTPUT_ERROR_LOSS_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic signed [15:0] prediction     [1:0];
    logic signed [15:0] target         [1:0];
    logic signed [15:0] error_gradient [1:0];
    logic grad_valid;
    logic train;
    logic signed [15:0] loss;
    logic loss_valid;
    logic [2:0]  sample_count;
    logic [15:0] epoch_count;

    output_error_unit #(
        .output_units(2),
        .batch_size  (4),
        .SFP_WIDTH   (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .prediction    (prediction),
        .target        (target),
        .error_gradient(error_gradient),
        .grad_valid    (grad_valid),
        .train         (train),
        .loss          (loss),
        .loss_valid    (loss_valid),
        .sample_count  (sample_count),
        .epoch_count   (epoch_count)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    int n_train  = 0;
    int n_lossv  = 0;
    int cyc      = 0;
    int acc_t[$];

    always @(posedge clk) begin
        cyc++;
        if (train) n_train++;
        if (loss_valid) n_lossv++;
        if (in_valid && in_ready) acc_t.push_back(cyc);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Present a pair and return at #1 after the accept edge.
    task automatic send(input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] t0, input logic [15:0] t1);
        int n = 0;
        prediction[0] = p0;
        prediction[1] = p1;
        target[0]     = t0;
        target[1]     = t1;
        in_valid      = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("ready_before_accept", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int lv;
        int tr;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prediction[i] = '0;
            target[i]     = '0;
        end

        // Reset
        tick(); tick(); tick();
        check("rst_in_ready",     16'(in_ready),     16'd0);
        check("rst_grad_valid",   16'(grad_valid),   16'd0);
        check("rst_train",        16'(train),        16'd0);
        check("rst_loss_valid",   16'(loss_valid),   16'd0);
        check("rst_loss",         loss,              16'd0);
        check("rst_grad0",        error_gradient[0], 16'd0);
        check("rst_sample_count", 16'(sample_count), 16'd0);
        check("rst_epoch",        epoch_count,       16'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst",  16'(in_ready),     16'd1);

        // Single sample: {0.75,0.25} - {1.0,0.0}
        send(16'h00C0, 16'h0040, 16'h0100, 16'h0000);
        check("single_grad0",  error_gradient[0], 16'hFFC0);
        check("single_grad1",  error_gradient[1], 16'h0040);
        check("single_gvalid", 16'(grad_valid),   16'd1);
        check("single_train",  16'(train),        16'd1);
        check("single_ready",  16'(in_ready),     16'd0);
        tick();
        check("single_gvalid_off", 16'(grad_valid),   16'd0);
        check("single_ready_back", 16'(in_ready),     16'd1);
        check("single_count",      16'(sample_count), 16'd1);
        check("single_grad_hold",  error_gradient[0], 16'hFFC0);

        // Batch loss: diff {0.5,-0.5} x4
        do_reset();
        lv = n_lossv;
        for (int k = 0; k < 4; k++) send(16'h0080, 16'h0000, 16'h0000, 16'h0080);
        check("batch_grad0",    error_gradient[0], 16'h0080);
        check("batch_grad1",    error_gradient[1], 16'hFF80);
        check("batch_count4",   16'(sample_count), 16'd4);
        check("batch_lv_early", 16'(loss_valid),   16'd0);
        tick();
        check("batch_lv",       16'(loss_valid),   16'(LOSS_EN));
        check("batch_loss",     loss,              LOSS_EN ? 16'h0040 : 16'h0000);
        check("batch_epoch",    epoch_count,       16'd1);
        check("batch_count0",   16'(sample_count), 16'd0);
        check("batch_rep_ready",16'(in_ready),     16'd0);
        tick();
        check("batch_lv_off",   16'(loss_valid),   16'd0);
        check("batch_ready",    16'(in_ready),     16'd1);
        check("batch_loss_hold",loss,              LOSS_EN ? 16'h0040 : 16'h0000);
        check("batch_lv_pulses",16'(n_lossv - lv), LOSS_EN ? 16'd1 : 16'd0);

        // Streaming: in_valid held high for 12 accepts
        do_reset();
        acc_t.delete();
        tr = n_train;
        lv = n_lossv;
        prediction[0] = 16'h0080; prediction[1] = 16'h0000;
        target[0]     = 16'h0000; target[1]     = 16'h0080;
        in_valid = 1'b1;
        n = 0;
        while (acc_t.size() < 12 && n < 200) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("stream_accepts", 16'(acc_t.size()), 16'd12);
        tick(); tick(); tick();
        for (int k = 1; k < acc_t.size(); k++) begin
            check($sformatf("stream_gap%0d", k), 16'(acc_t[k] - acc_t[k-1]),
                  (k % 4 == 0) ? 16'd3 : 16'd2);
        end
        check("stream_trains", 16'(n_train - tr), 16'd12);
        check("stream_losses", 16'(n_lossv - lv), LOSS_EN ? 16'd3 : 16'd0);
        check("stream_epoch",  epoch_count,       16'd3);
        check("stream_count",  16'(sample_count), 16'd0);

        // Mid-batch reset: 2 samples of diff {1,1}, abort, then 4 of {0.5,0.5}
        do_reset();
        lv = n_lossv;
        send(16'h0100, 16'h0100, 16'h0000, 16'h0000);
        send(16'h0100, 16'h0100, 16'h0000, 16'h0000);
        do_reset();
        tick(); tick();
        check("abort_no_lv", 16'(n_lossv - lv),   16'd0);
        check("abort_epoch", epoch_count,         16'd0);
        check("abort_count", 16'(sample_count),   16'd0);
        for (int k = 0; k < 4; k++) send(16'h0080, 16'h0080, 16'h0000, 16'h0000);
        tick();
        check("abort_loss",  loss,                LOSS_EN ? 16'h0040 : 16'h0000);
        check("abort_lv",    16'(loss_valid),     16'(LOSS_EN));
        check("abort_epoch1",epoch_count,         16'd1);

        // Saturation: clamped diffs and accumulator
        do_reset();
        send(16'h8000, 16'h0000, 16'h7FFF, 16'h0000);
        check("sat_grad_neg",  error_gradient[0], 16'h8000);
        check("sat_grad_zero", error_gradient[1], 16'h0000);
        send(16'h7FFF, 16'h7F00, 16'h8000, 16'h0000);
        check("sat_grad_pos",  error_gradient[0], 16'h7FFF);
        check("sat_grad_big",  error_gradient[1], 16'h7F00);
        send(16'h7F00, 16'h7F00, 16'h0000, 16'h0000);
        send(16'h7F00, 16'h7F00, 16'h0000, 16'h0000);
        tick();
        check("sat_loss",  loss,             LOSS_EN ? 16'h0FFF : 16'h0000);
        check("sat_lv",    16'(loss_valid),  16'(LOSS_EN));
        check("sat_epoch", epoch_count,      16'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_error_unit.md
# output_error_unit

Output-error stage placed directly downstream of the final perceptron layer. It accepts one prediction vector and its target vector per handshake. It produces the per-output error gradient and a one-cycle training strobe, which drive the last layer's `error_gradient_next_layer` and `training` inputs. It also accumulates squared error over a fixed batch and reports mean-squared loss plus an epoch count.

## Interface
Parameters:
- `output_units`, 2, number of outputs of the final layer.
- `batch_size`, 4, samples per loss report. `batch_size*output_units` must be a power of two (elaboration-time `$error` otherwise).

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  prediction/target pair valid.
- `in_ready`  output  1  block can accept a pair this cycle.
- `prediction[output_units-1:0]`  input  sfp each  outputs of the final layer.
- `target[output_units-1:0]`  input  sfp each  expected outputs.
- `error_gradient[output_units-1:0]`  output  sfp each  registered gradient, `prediction - target`.
- `grad_valid`  output  1  `error_gradient` valid, one-cycle pulse.
- `train`  output  1  training strobe to the layers. Identical to `grad_valid`.
- `loss`  output  sfp  mean squared error of the last completed batch.
- `loss_valid`  output  1  one-cycle pulse when `loss` is updated.
- `sample_count`  output  `$clog2(batch_size+1)`  samples accepted in the current batch.
- `epoch_count`  output  16  completed batches, wraps modulo 2^16.

## Operation
- The FSM has three states:
  - ACCEPT: `in_ready=1`.
  - GRAD: `in_ready=0`, `grad_valid=train=1`.
  - REPORT: `in_ready=0`, `loss_valid=1`.
- Transitions:
  - ACCEPT goes to GRAD when `in_valid` is high. Otherwise it stays in ACCEPT.
  - GRAD goes to REPORT if `sample_count==batch_size`. Otherwise it goes to ACCEPT.
  - REPORT goes to ACCEPT unconditionally.
- Accept edge:
  - `diff_i = sfp_sub(prediction[i], target[i])` is registered into `error_gradient[i]`.
  - `sq = Σ sfp_mul(diff_i, diff_i)` is added into the internal accumulator `acc`.
  - `sample_count` increments.
- Accumulation saturates at the largest positive sfp value and never wraps negative.
- GRAD→REPORT edge:
  - `loss <= acc >>> $clog2(batch_size*output_units)`.
  - `acc <= 0`.
  - `sample_count <= 0`.
  - `epoch_count` increments.
- `error_gradient` and `loss` hold their values between updates.
- The single-cycle GRAD state lets the layers commit weight updates on the `train` edge before the next prediction is accepted. This prevents a stale-weight sample.
- `in_valid` while `in_ready=0` is ignored. The source holds its data until accepted.
- Reset:
  - State goes to ACCEPT.
  - `acc`, `error_gradient`, `loss`, `sample_count` and `epoch_count` go to 0.
  - `grad_valid`, `train` and `loss_valid` go to 0.
  - `in_ready` is forced 0 while `rst` is high.
  - Reset in any state abandons a partial batch with no `loss_valid` pulse.

## Timing
- Accept at edge N puts the block in GRAD for cycle N→N+1. `grad_valid/train` are high exactly that cycle.
- If the batch is not complete, `in_ready` is high again from edge N+1. Back-to-back throughput is one sample per 2 cycles.
- On the last sample of a batch, REPORT occupies cycle N+1→N+2 with `loss_valid=1` and the new `loss` visible. `in_ready` returns at edge N+2, giving 3 cycles for that sample.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` to any output.

## Configuration
- `OUTPUT_ERROR_LOSS_EN` defined: `acc`, squared-error logic, `loss` and `loss_valid` are implemented as described.
- `OUTPUT_ERROR_LOSS_EN` undefined:
  - No accumulator or multipliers are built.
  - `loss` is tied to 0 and `loss_valid` is tied to 0.
  - The REPORT state still occurs, and `sample_count` and `epoch_count` behave identically. Handshake timing is unchanged.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release.
  - All outputs are 0 during reset, and `in_ready=0` while `rst=1`.
  - `in_ready=1` in the first cycle after release.
- **Single sample:** `output_units=2`, prediction {0.75, 0.25}, target {1.0, 0.0}.
  - `error_gradient` = {-0.25, +0.25}.
  - `grad_valid=train=1` for exactly one cycle after the accept edge, with `in_ready=0` in that cycle.
- **Batch loss:** 4 samples, each with diff {0.5, -0.5}.
  - `acc=2.0`, so `loss=2.0/8=0.25`.
  - `loss_valid` pulses once in the cycle after the 4th `grad_valid`.
  - `epoch_count=1`, `sample_count=0`.
- **Streaming:** hold `in_valid` high for 12 samples.
  - Accepts are spaced 2,2,2,3 cycles repeating.
  - Exactly 12 `train` pulses and 3 `loss_valid` pulses occur.
  - No sample is accepted while `in_ready=0`.
- **Mid-batch reset:** assert `rst` after 2 samples of diff {1.0, 1.0}, then run 4 samples of diff {0.5, 0.5}.
  - There is no `loss_valid` for the aborted batch.
  - The next report gives `loss=0.25` and `epoch_count=1`.
- **Saturation and macro off:**
  - Diffs near the sfp maximum give `acc` clamped and `loss` = sfp_max >>> 3, never negative.
  - With `OUTPUT_ERROR_LOSS_EN` undefined, the same stimulus gives `loss=0` and `loss_valid=0`, with identical `in_ready`, `train` and `epoch_count` traces.
